mm_operand_loader: RTL and testbench
====================================

// Module: mm_operand_loader
// PURPOSE
//  Upstream stage of the blocked multiplier (O=A*B). Accepts one valid/ready stream of 16-bit elements:
//  A then B, each N*N, row-major. Writes A and B into their operand RAMs at addr = row*N+col.
//  Fires a one-cycle start to the multiplier, then holds the stream off until the multiplier reports done.
// PARAMETERS
//  N   16  matrix dimension; N*N must fit in AW bits
//  DW  16  element width
//  AW  8   operand RAM address width
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset, asynchronous, active-high
//  s_valid  in   1   stream element valid
//  s_ready  out  1   loader accepts element
//  s_data   in   DW  element (A row-major, then B row-major)
//  s_last   in   1   high on final B element (beat 2*N*N-1)
//  wea      out  1   A RAM write enable
//  wa_addr  out  AW  A RAM write address
//  wa_data  out  DW  A RAM write data
//  web      out  1   B RAM write enable
//  wb_addr  out  AW  B RAM write address
//  wb_data  out  DW  B RAM write data
//  mm_start out  1   one-cycle start pulse to multiplier
//  mm_done  in   1   one-cycle done pulse from multiplier
//  busy     out  1   high from first accepted beat until mm_done
//  err_len  out  1   sticky framing error
// BEHAVIOUR
//  - Reset (async): state=IDLE, elem_cnt=0.
//    s_ready, wea, web, mm_start, busy, err_len = 0; addr/data outputs = 0.
//  - FSM: IDLE -> LOAD_A -> LOAD_B -> KICK -> WAIT -> IDLE.
//  - IDLE: s_ready=1. First accepted beat is A[0], moves to LOAD_A.
//  - LOAD_A / LOAD_B: s_ready=1. Accept = s_valid & s_ready.
//  - elem_cnt counts accepted beats within the current matrix, 0..N*N-1.
//  - Writes are registered: a beat accepted at cycle t gives wea/web=1 at t+1.
//    wX_addr = elem_cnt at accept; wX_data = s_data. Write enables are low in any cycle without an accept.
//  - A beat N*N-1 accepted: elem_cnt wraps to 0, state -> LOAD_B.
//  - B beat N*N-1 accepted: state -> KICK, s_ready drops to 0 in the next cycle.
//  - KICK: the final web is on the bus this cycle. mm_start=1 for exactly one cycle, asserted in the cycle
//    after KICK, so it is strictly after the last RAM write. Then state -> WAIT.
//  - WAIT: s_ready=0. On mm_done -> IDLE; s_ready=1 from the next cycle. busy falls with the state change.
//  - Load-to-start latency: last B accept at t, web at t+1, mm_start at t+2.
//  - s_last asserted on any accepted beat other than B[N*N-1]: err_len<=1, beat written normally, then abort:
//    state -> IDLE, elem_cnt=0, no mm_start.
//  - B[N*N-1] accepted with s_last=0: err_len<=1, proceed to KICK normally.
//  - err_len is sticky; only rst clears it.
//  - mm_done outside WAIT is ignored. mm_done in the same cycle WAIT is entered is honoured.
//  - s_valid low mid-matrix: no write, elem_cnt holds. There is no timeout.
//  - Back-to-back frames: the next frame's A[0] is accepted no earlier than 1 cycle after mm_done.
// STRUCTURE
//  - Shared package mm_pkg: N, Tn, DW, AW constants; typedef enum logic [2:0] ld_state_t
//    {IDLE, LOAD_A, LOAD_B, KICK, WAIT}; typedef logic [DW-1:0] elem_t.
//  - Single flat module. Counter and FSM are small, no sub-module.
//  - Elaboration check: N*N <= 2**AW.
// TESTING
//  - Full frame, s_valid held high: 512 beats, data=index.
//    -> wa_addr 0..255 with data 0..255; wb_addr 0..255 with data 256..511.
//    -> mm_start exactly once, 2 cycles after beat 511; err_len=0.
//  - Random s_valid gaps (50% duty).
//    -> identical RAM contents; no write in any gap cycle; mm_start count = 1.
//  - s_last on beat 100.
//    -> err_len=1; 101 A writes; no mm_start; next clean frame completes with mm_start.
//  - No s_last on beat 511.
//    -> err_len=1, mm_start still pulses once.
//  - mm_done delayed 300 cycles, s_valid high.
//    -> s_ready=0 and busy=1 throughout WAIT; s_ready=1 the cycle after mm_done.
//    -> spurious mm_done in LOAD_A is ignored.
//  - rst asserted mid-LOAD_B (beat 300).
//    -> all outputs 0 immediately; the next frame loads from A[0] at wa_addr 0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants and types for the blocked matrix multiplier datapath.
package mm_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned Tn = N * N;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, KICK, WAIT} ld_state_t;

  typedef logic [DW-1:0] elem_t;

endpackage

// File: rtl/mm_operand_loader.sv
// Streams A then B (row-major) into the operand RAMs, kicks the multiplier once the
// last B write is on the bus, and holds the stream off until the multiplier is done.
module mm_operand_loader
  import mm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          wea,
  output logic [AW-1:0] wa_addr,
  output logic [DW-1:0] wa_data,
  output logic          web,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          mm_start,
  input  logic          mm_done,
  output logic          busy,
  output logic          err_len
);

  if (Tn > (2 ** AW)) begin : gen_size_check
    $error("mm_operand_loader: N*N does not fit in AW address bits");
  end

  localparam logic [AW-1:0] LastIdx = AW'(Tn - 1);

  ld_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          wea_q, web_q, start_q;
  logic [AW-1:0] wa_addr_q, wb_addr_q;
  elem_t         wa_data_q, wb_data_q;

  logic accept, last_elem, in_a, in_b;

  assign accept    = s_valid & ready_q;
  assign last_elem = (cnt_q == LastIdx);
  assign in_a      = (state_q == IDLE) || (state_q == LOAD_A);
  assign in_b      = (state_q == LOAD_B);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, LOAD_A: begin
        if (accept) begin
          if (s_last) begin
            // Premature frame end: keep the write, drop the frame.
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (last_elem) begin
            state_d = LOAD_B;
            cnt_d   = '0;
          end else begin
            state_d = LOAD_A;
            cnt_d   = cnt_q + AW'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (last_elem) begin
            err_d   = err_q | ~s_last;
            state_d = KICK;
            cnt_d   = '0;
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      KICK:    state_d = WAIT;
      WAIT:    if (mm_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == LOAD_A) || (state_d == LOAD_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      wea_q     <= 1'b0;
      web_q     <= 1'b0;
      start_q   <= 1'b0;
      wa_addr_q <= '0;
      wa_data_q <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      wea_q   <= accept & in_a;
      web_q   <= accept & in_b;
      // KICK is the cycle the last B write is on the bus, so start follows it.
      start_q <= (state_q == KICK);
      if (accept && in_a) begin
        wa_addr_q <= cnt_q;
        wa_data_q <= s_data;
      end
      if (accept && in_b) begin
        wb_addr_q <= cnt_q;
        wb_data_q <= s_data;
      end
    end
  end

  assign s_ready  = ready_q;
  assign wea      = wea_q;
  assign wa_addr  = wa_addr_q;
  assign wa_data  = wa_data_q;
  assign web      = web_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign mm_start = start_q;
  assign busy     = (state_q != IDLE);
  assign err_len  = err_q;

endmodule

// File: tb/tb_mm_operand_loader.sv
// Self-checking bench for mm_operand_loader: table of frame scenarios plus reset corner cases,
// RAM writes checked against an index-based model of where each beat must land.
module tb_mm_operand_loader;
  import mm_pkg::*;

  localparam int FR = 2 * Tn;

  logic          clk = 1'b0;
  logic          rst, s_valid, s_ready, s_last;
  logic          wea, web, mm_start, mm_done, busy, err_len;
  logic [DW-1:0] s_data, wa_data, wb_data;
  logic [AW-1:0] wa_addr, wb_addr;

  always #5 clk = ~clk;

  mm_operand_loader dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .wea      (wea),
    .wa_addr  (wa_addr),
    .wa_data  (wa_data),
    .web      (web),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .busy     (busy),
    .err_len  (err_len)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int gap_pct;
    int last_at;     // beat carrying s_last, -1 for none
    int done_delay;
    int spur_at;     // beat during which a spurious mm_done is driven, -1 for none
    int do_reset;
    int exp_err;
    int exp_starts;
    int exp_a;
    int exp_b;
  } vec_t;

  wr_t log_a[$], log_b[$];
  int  cyc, starts, start_cyc, last_acc_cyc;
  bit  prev_acc;
  int  checks, errors;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observer: write log, start pulses, and "no write without a preceding accept".
  initial begin
    cyc = 0; starts = 0; start_cyc = 0; last_acc_cyc = 0; prev_acc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_acc = 0;
      end else begin
        if (wea || web) begin
          checks++;
          if (!prev_acc) begin
            errors++;
            $display("FAIL write_without_accept: cyc %0d wea=%0b web=%0b, expected no write",
                     cyc, wea, web);
          end
        end
        if (wea) log_a.push_back(wr_t'{addr: wa_addr, data: wa_data});
        if (web) log_b.push_back(wr_t'{addr: wb_addr, data: wb_data});
        if (mm_start) begin
          starts++;
          start_cyc = cyc;
        end
        prev_acc = s_valid && s_ready;
        if (prev_acc) last_acc_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_outputs", {s_ready, wea, web, mm_start, busy, err_len,
                          wa_addr, wb_addr, wa_data, wb_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {s_ready, busy}, 2'b10);
  endtask

  task automatic send_beats(input int n, input int last_at, input int spur_at, input int gap);
    bit ok;
    int bound;
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
        s_valid = 1'b0;
        mm_done = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = DW'(i);
      s_last  = (i == last_at);
      mm_done = (i == spur_at);
      ok = 0;
      bound = 0;
      while (!ok && bound <= 1000) begin
        ok = s_ready;
        @(posedge clk);
        #1;
        bound++;
      end
      if (!ok) begin
        errors++;
        $display("FAIL beat_accept_timeout: beat %0d not accepted, expected s_ready=1", i);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    mm_done = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int  nsend, bad, w;
    bit  exp_start;
    wr_t ea[$], eb[$];
    log_a.delete();
    log_b.delete();
    starts = 0;
    nsend = (v.last_at >= 0 && v.last_at < FR - 1) ? v.last_at + 1 : FR;
    exp_start = (nsend == FR);
    // Model: beat i lands in A at i, or in B at i-Tn, carrying its own index.
    for (int i = 0; i < nsend; i++) begin
      if (i < Tn) ea.push_back(wr_t'{addr: AW'(i), data: DW'(i)});
      else        eb.push_back(wr_t'{addr: AW'(i - Tn), data: DW'(i)});
    end
    send_beats(nsend, v.last_at, v.spur_at, v.gap_pct);
    if (exp_start) begin
      w = 0;
      while (starts == 0 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("start_seen", 64'(starts > 0), 64'd1);
      chk("start_latency", 64'(start_cyc - last_acc_cyc), 64'd2);
      @(posedge clk);
      #1;
      bad = 0;
      for (int d = 0; d < v.done_delay; d++) begin
        if (s_ready !== 1'b0 || busy !== 1'b1) bad++;
        @(posedge clk);
        #1;
      end
      chk("wait_hold_off", 64'(bad), 64'd0);
      mm_done = 1'b1;
      @(posedge clk);
      #1;
      mm_done = 1'b0;
      chk("ready_after_done", {s_ready, busy}, 2'b10);
    end else begin
      repeat (5) @(posedge clk);
      #1;
      chk("idle_after_abort", {s_ready, busy}, 2'b10);
    end
    chk("a_write_count", 64'(log_a.size()), 64'(v.exp_a));
    chk("b_write_count", 64'(log_b.size()), 64'(v.exp_b));
    bad = 0;
    for (int i = 0; i < log_a.size() && i < ea.size(); i++) if (log_a[i] !== ea[i]) bad++;
    chk("a_contents", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < log_b.size() && i < eb.size(); i++) if (log_b[i] !== eb[i]) bad++;
    chk("b_contents", 64'(bad), 64'd0);
    chk("start_count", 64'(starts), 64'(v.exp_starts));
    chk("err_len", 64'(err_len), 64'(v.exp_err));
  endtask

  initial begin
    vec_t clean;
    checks = 0;
    errors = 0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; mm_done = 1'b0;

    //          gap last  dly  spur rst err st  a    b
    vecs[0] = '{0,  511, 3,   -1,  0,  0,  1,  256, 256};
    vecs[1] = '{50, 511, 5,   -1,  0,  0,  1,  256, 256};
    vecs[2] = '{0,  511, 300, 50,  0,  0,  1,  256, 256};
    vecs[3] = '{0,  100, 0,   -1,  0,  1,  0,  101, 0};
    vecs[4] = '{0,  511, 2,   -1,  0,  1,  1,  256, 256};
    vecs[5] = '{0,  -1,  4,   -1,  1,  1,  1,  256, 256};
    vecs[6] = '{25, 300, 0,   -1,  1,  1,  0,  256, 45};
    vecs[7] = '{30, 511, 1,   -1,  0,  1,  1,  256, 256};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (vecs[k].do_reset != 0) do_reset();
      run_frame(vecs[k]);
    end

    // Reset in the middle of B; the next frame must restart from A[0].
    send_beats(301, -1, -1, 0);
    chk("mid_load_b_busy", 64'(busy), 64'd1);
    do_reset();
    clean = '{0, 511, 0, -1, 0, 0, 1, 256, 256};
    run_frame(clean);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
